fb_rd_line_scheduler: RTL and testbench

- Frame-level sequencer for the frame-buffer read path.
- Picks the most recently completed write buffer and issues one read request per video line: strobe, byte address and byte size.
- Waits for each line's last beat on the stream output before issuing the next line.
- Publishes the buffer being read so the write side can avoid it.

---
 rtl/fb_rd_line_scheduler.sv | 145 ++++++++++++++
 tb/tb_fb_rd_line_scheduler.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_rd_line_scheduler.sv
// Frame-buffer read sequencer: one read request per line of the most recently completed buffer.
// Optional frame repeat when the writer stalls: define FB_RD_REPEAT_FRAME_EN.
module fb_rd_line_scheduler #(
  parameter int unsigned ADDR_WIDTH         = 32,
  parameter int unsigned MAX_PKT_SIZE_B     = 2048,
  parameter int unsigned MAX_PKT_SIZE_WIDTH = $clog2(MAX_PKT_SIZE_B),
  parameter int unsigned LINES_WIDTH        = 12,
  parameter int unsigned BUF_CNT            = 3,
  parameter int unsigned BUF_IDX_WIDTH      = $clog2(BUF_CNT)
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          en_i,
  input  logic [ADDR_WIDTH-1:0]         base_addr_i,
  input  logic [ADDR_WIDTH-1:0]         frame_stride_i,
  input  logic [ADDR_WIDTH-1:0]         line_stride_i,
  input  logic [MAX_PKT_SIZE_WIDTH-1:0] line_size_i,
  input  logic [LINES_WIDTH-1:0]        lines_per_frame_i,
  input  logic                          wr_frame_done_i,
  input  logic [BUF_IDX_WIDTH-1:0]      wr_buf_i,
  input  logic                          line_done_i,
  output logic                          rd_stb_o,
  output logic [ADDR_WIDTH-1:0]         addr_o,
  output logic [MAX_PKT_SIZE_WIDTH-1:0] pkt_size_o,
  output logic [BUF_IDX_WIDTH-1:0]      rd_buf_o,
  output logic                          sof_o,
  output logic                          busy_o
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e                        state_q, state_d;
  logic [BUF_IDX_WIDTH-1:0]      latest_buf_q, latest_buf_d;
  logic                          new_frame_q, new_frame_d;
  logic [LINES_WIDTH-1:0]        line_cnt_q, line_cnt_d;
  logic [ADDR_WIDTH-1:0]         line_addr_q, line_addr_d;
  logic [ADDR_WIDTH-1:0]         line_stride_q, line_stride_d;
  logic [LINES_WIDTH-1:0]        lines_q, lines_d;
  logic [MAX_PKT_SIZE_WIDTH-1:0] pkt_size_q, pkt_size_d;
  logic [BUF_IDX_WIDTH-1:0]      rd_buf_q, rd_buf_d;

  logic                          start;
  logic [BUF_IDX_WIDTH-1:0]      start_buf;

`ifdef FB_RD_REPEAT_FRAME_EN
  logic have_frame_q, have_frame_d;

  // Without a fresh frame, re-read the last buffer so the output cadence never stalls.
  assign start     = en_i & (new_frame_q | have_frame_q);
  assign start_buf = new_frame_q ? latest_buf_q : rd_buf_q;
  assign have_frame_d = have_frame_q | wr_frame_done_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      have_frame_q <= 1'b0;
    end else begin
      have_frame_q <= have_frame_d;
    end
  end
`else
  assign start     = en_i & new_frame_q;
  assign start_buf = latest_buf_q;
`endif

  always_comb begin
    state_d       = state_q;
    latest_buf_d  = latest_buf_q;
    new_frame_d   = new_frame_q;
    line_cnt_d    = line_cnt_q;
    line_addr_d   = line_addr_q;
    line_stride_d = line_stride_q;
    lines_d       = lines_q;
    pkt_size_d    = pkt_size_q;
    rd_buf_d      = rd_buf_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          new_frame_d = 1'b0;
          // An empty frame is consumed without any request.
          if (lines_per_frame_i != '0 && line_size_i != '0) begin
            lines_d       = lines_per_frame_i;
            pkt_size_d    = line_size_i;
            line_stride_d = line_stride_i;
            rd_buf_d      = start_buf;
            line_addr_d   = base_addr_i + frame_stride_i * ADDR_WIDTH'(start_buf);
            line_cnt_d    = '0;
            state_d       = StIssue;
          end
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (line_done_i) begin
          if (line_cnt_q == lines_q - LINES_WIDTH'(1)) begin
            state_d = StIdle;
          end else begin
            line_cnt_d  = line_cnt_q + LINES_WIDTH'(1);
            line_addr_d = line_addr_q + line_stride_q;
            state_d     = StIssue;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // A completion arriving in the start cycle is kept for the following frame.
    if (wr_frame_done_i) begin
      latest_buf_d = wr_buf_i;
      new_frame_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= StIdle;
      latest_buf_q  <= '0;
      new_frame_q   <= 1'b0;
      line_cnt_q    <= '0;
      line_addr_q   <= '0;
      line_stride_q <= '0;
      lines_q       <= '0;
      pkt_size_q    <= '0;
      rd_buf_q      <= '0;
    end else begin
      state_q       <= state_d;
      latest_buf_q  <= latest_buf_d;
      new_frame_q   <= new_frame_d;
      line_cnt_q    <= line_cnt_d;
      line_addr_q   <= line_addr_d;
      line_stride_q <= line_stride_d;
      lines_q       <= lines_d;
      pkt_size_q    <= pkt_size_d;
      rd_buf_q      <= rd_buf_d;
    end
  end

  assign rd_stb_o   = (state_q == StIssue);
  assign sof_o      = rd_stb_o & (line_cnt_q == '0);
  assign busy_o     = (state_q != StIdle);
  assign addr_o     = line_addr_q;
  assign pkt_size_o = pkt_size_q;
  assign rd_buf_o   = rd_buf_q;

endmodule

// File: tb/tb_fb_rd_line_scheduler.sv
// Randomized self-checking bench for fb_rd_line_scheduler (default build, no frame repeat).
// Expected addresses come from base + buf*frame_stride + line*line_stride.
module tb_fb_rd_line_scheduler;
  localparam int AW = 32;
  localparam int SW = 11;
  localparam int LW = 12;
  localparam int BW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [AW-1:0] cur_base, cur_fstride, cur_lstride;
  logic [SW-1:0] cur_size;
  logic [LW-1:0] cur_lines;
  logic          wr_frame_done;
  logic [BW-1:0] wr_buf;
  logic          line_done;
  logic          rd_stb_o, sof_o, busy_o;
  logic [AW-1:0] addr_o;
  logic [SW-1:0] pkt_size_o;
  logic [BW-1:0] rd_buf_o;

  int tests = 0;
  int fails = 0;
  int model_latest = 0;
  bit model_pending = 1'b0;
  int inj_q[$];
  int drop_en_line = -1;

  fb_rd_line_scheduler dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .en_i             (en),
    .base_addr_i      (cur_base),
    .frame_stride_i   (cur_fstride),
    .line_stride_i    (cur_lstride),
    .line_size_i      (cur_size),
    .lines_per_frame_i(cur_lines),
    .wr_frame_done_i  (wr_frame_done),
    .wr_buf_i         (wr_buf),
    .line_done_i      (line_done),
    .rd_stb_o         (rd_stb_o),
    .addr_o           (addr_o),
    .pkt_size_o       (pkt_size_o),
    .rd_buf_o         (rd_buf_o),
    .sof_o            (sof_o),
    .busy_o           (busy_o)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_wr(input int b);
    wr_frame_done = 1'b1;
    wr_buf        = BW'(b);
    tick();
    wr_frame_done = 1'b0;
    model_latest  = b;
    model_pending = 1'b1;
  endtask

  task automatic randomize_cfg;
    cur_base    = $urandom;
    cur_fstride = $urandom;
    cur_lstride = $urandom;
    cur_size    = SW'($urandom_range(1, 2047));
    cur_lines   = LW'($urandom_range(1, 5));
  endtask

  // Follows one frame on buffer b; the config in effect at frame start is the one on the inputs now.
  task automatic run_frame(input int b, input int dmin, input int dmax, input bit scramble,
                           input string tag);
    logic [AW-1:0] base, fs, ls, exp_addr;
    logic [SW-1:0] size;
    int            lines;
    bit            early;
    base  = cur_base;
    fs    = cur_fstride;
    ls    = cur_lstride;
    size  = cur_size;
    lines = int'(cur_lines);
    for (int i = 0; i < lines; i++) begin
      if (i == 0) begin
        for (int t = 0; t < 40 && rd_stb_o !== 1'b1; t++) tick();
      end
      tests++;
      if (rd_stb_o !== 1'b1) begin
        fails++;
        $display("FAIL %s strobe line %0d: rd_stb_o=%b required 1", tag, i, rd_stb_o);
        inj_q.delete();
        return;
      end
      exp_addr = base + AW'(b) * fs + AW'(i) * ls;
      tests++;
      if (addr_o !== exp_addr || pkt_size_o !== size || sof_o !== (i == 0) ||
          rd_buf_o !== BW'(b)) begin
        fails++;
        $display("FAIL %s line %0d: addr=%h size=%0d sof=%b buf=%0d required addr=%h size=%0d sof=%b buf=%0d",
                 tag, i, addr_o, pkt_size_o, sof_o, rd_buf_o, exp_addr, size, (i == 0), b);
      end
      if (scramble && i == 0) randomize_cfg();
      if (i == drop_en_line) en = 1'b0;
      // Sometimes hold line_done through the strobe cycle, where it must be ignored.
      early = (dmin == 0) && ($urandom_range(0, 3) == 0);
      if (early) line_done = 1'b1;
      tick();
      tests++;
      if (rd_stb_o !== 1'b0 || busy_o !== 1'b1) begin
        fails++;
        $display("FAIL %s wait line %0d: rd_stb_o=%b busy_o=%b required 0 1", tag, i, rd_stb_o,
                 busy_o);
      end
      if (!early) begin
        for (int d = $urandom_range(dmin, dmax); d > 0; d--) begin
          if (inj_q.size() != 0) pulse_wr(inj_q.pop_front());
          else tick();
        end
        line_done = 1'b1;
      end
      tick();
      line_done = 1'b0;
    end
    inj_q.delete();
    tests++;
    if (busy_o !== 1'b0 || rd_stb_o !== 1'b0) begin
      fails++;
      $display("FAIL %s frame end: busy_o=%b rd_stb_o=%b required 0 0", tag, busy_o, rd_stb_o);
    end
  endtask

  task automatic expect_quiet(input int cycles, input string tag);
    bit bad = 1'b0;
    for (int t = 0; t < cycles; t++) begin
      if (rd_stb_o !== 1'b0 || busy_o !== 1'b0) bad = 1'b1;
      tick();
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL %s: activity seen (rd_stb_o=%b busy_o=%b) required idle", tag, rd_stb_o,
               busy_o);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    en = 1'b0;
    wr_frame_done = 1'b0;
    wr_buf = '0;
    line_done = 1'b0;
    cur_base = '0; cur_fstride = '0; cur_lstride = '0; cur_size = '0; cur_lines = '0;
    repeat (3) tick();
    tests++;
    if ({rd_stb_o, sof_o, busy_o, addr_o, pkt_size_o, rd_buf_o} !== '0) begin
      fails++;
      $display("FAIL reset: stb=%b sof=%b busy=%b addr=%h size=%0d buf=%0d required all 0",
               rd_stb_o, sof_o, busy_o, addr_o, pkt_size_o, rd_buf_o);
    end
    rst_n = 1'b1;
    tick();
    model_latest = 0;
    model_pending = 1'b0;
  endtask

  task automatic test_basic_frame;
    cur_base = 32'h1000_0000; cur_fstride = 32'h0010_0000; cur_lstride = 32'h0000_0800;
    cur_size = 11'd1920; cur_lines = 12'd4;
    en = 1'b1;
    pulse_wr(1);
    tests++;
    if (rd_stb_o !== 1'b0) begin
      fails++;
      $display("FAIL basic start latency: rd_stb_o=%b required 0 before start edge", rd_stb_o);
    end
    tick();
    tests++;
    if (rd_stb_o !== 1'b1) begin
      fails++;
      $display("FAIL basic start latency: rd_stb_o=%b required 1 one cycle after start", rd_stb_o);
    end
    model_pending = 1'b0;
    run_frame(1, 19, 19, 1'b0, "basic");
  endtask

  task automatic test_buffer_selection;
    randomize_cfg();
    pulse_wr(1);
    model_pending = 1'b0;
    inj_q.push_back(0);
    inj_q.push_back(2);
    run_frame(1, 3, 5, 1'b0, "bufsel_first");
    model_pending = 1'b0;
    run_frame(2, 0, 3, 1'b0, "bufsel_next");
  endtask

  task automatic test_simultaneous;
    randomize_cfg();
    en = 1'b0;
    pulse_wr(1);
    expect_quiet(3, "simul_disabled");
    en = 1'b1;
    wr_frame_done = 1'b1;
    wr_buf = 2'd0;
    tick();
    wr_frame_done = 1'b0;
    model_latest = 0;
    model_pending = 1'b1;
    run_frame(1, 0, 3, 1'b0, "simul_current");
    model_pending = 1'b0;
    run_frame(0, 0, 3, 1'b0, "simul_following");
  endtask

  task automatic test_degenerate;
    for (int k = 0; k < 2; k++) begin
      randomize_cfg();
      if (k == 0) cur_lines = '0;
      else cur_size = '0;
      en = 1'b1;
      pulse_wr(2);
      model_pending = 1'b0;
      expect_quiet(10, k == 0 ? "degen_lines0" : "degen_size0");
      randomize_cfg();
      expect_quiet(10, "degen_new_frame_cleared");
    end
    pulse_wr(0);
    model_pending = 1'b0;
    run_frame(0, 0, 3, 1'b0, "degen_recover");
  endtask

  task automatic test_enable_mid_frame;
    randomize_cfg();
    cur_lines = 12'd4;
    en = 1'b1;
    pulse_wr(2);
    model_pending = 1'b0;
    drop_en_line = 1;
    run_frame(2, 0, 3, 1'b0, "en_drop");
    drop_en_line = -1;
    pulse_wr(1);
    expect_quiet(10, "en_low_no_start");
    en = 1'b1;
    model_pending = 1'b0;
    run_frame(1, 0, 3, 1'b0, "en_restore");
  endtask

  task automatic test_reset_mid_frame;
    randomize_cfg();
    cur_base = 32'hA000_0000 | cur_base;
    cur_lines = 12'd3;
    pulse_wr(1);
    for (int t = 0; t < 40 && rd_stb_o !== 1'b1; t++) tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({rd_stb_o, sof_o, busy_o, addr_o, pkt_size_o, rd_buf_o} !== '0) begin
      fails++;
      $display("FAIL async reset: stb=%b sof=%b busy=%b addr=%h size=%0d buf=%0d required all 0",
               rd_stb_o, sof_o, busy_o, addr_o, pkt_size_o, rd_buf_o);
    end
    tick();
    rst_n = 1'b1;
    model_latest = 0;
    model_pending = 1'b0;
    expect_quiet(10, "post_reset_idle");
  endtask

  task automatic test_no_repeat;
    randomize_cfg();
    pulse_wr(0);
    model_pending = 1'b0;
    run_frame(0, 0, 2, 1'b0, "norep_frame");
    expect_quiet(20, "no_repeat_idle");
    pulse_wr(2);
    model_pending = 1'b0;
    run_frame(2, 0, 2, 1'b0, "norep_next");
  endtask

  task automatic test_random_frames;
    int b;
    en = 1'b1;
    for (int n = 0; n < 10; n++) begin
      if (!model_pending) begin
        randomize_cfg();
        pulse_wr($urandom_range(0, 2));
      end
      model_pending = 1'b0;
      b = model_latest;
      if ($urandom_range(0, 1) == 1) inj_q.push_back($urandom_range(0, 2));
      run_frame(b, 0, 4, 1'b1, "random");
    end
    for (int t = 0; t < 40 && busy_o !== 1'b0; t++) tick();
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_buffer_selection();
    test_simultaneous();
    test_degenerate();
    test_enable_mid_frame();
    test_reset_mid_frame();
    test_no_repeat();
    test_random_frames();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
